// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Multi-cycle RV32I control FSM. Sequences fetch, decode,
//               execute, memory and writeback, handles memory wait states,
//               an optional iterative mul/div stall, illegal-opcode trapping
//               and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int unsigned EN_MULDIV     = 0,
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic             MemReq,
    output logic             MemRW,
    output logic             RegWEn,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             Branch,
    output logic             BrUn,
    output logic [3:0]       alu_control,
    output logic             md_start,
    output logic             md_busy,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    // Opcodes
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_f7_muldiv = 7'b0000001;

    // ALU operations
    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_and  = 4'b0010;
    localparam logic [3:0] c_alu_or   = 4'b0011;
    localparam logic [3:0] c_alu_xor  = 4'b0100;
    localparam logic [3:0] c_alu_sll  = 4'b0101;
    localparam logic [3:0] c_alu_srl  = 4'b0110;
    localparam logic [3:0] c_alu_sra  = 4'b0111;
    localparam logic [3:0] c_alu_slt  = 4'b1000;
    localparam logic [3:0] c_alu_sltu = 4'b1001;

    localparam bit         c_md_en   = (EN_MULDIV != 0);
    localparam logic [7:0] c_md_load = 8'(MULDIV_CYCLES - 1);

    typedef enum logic [4:0] {
        S_IDLE     = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_EXECR    = 5'd3,
        S_EXECI    = 5'd4,
        S_ALUWB    = 5'd5,
        S_MEMADR   = 5'd6,
        S_MEMREAD  = 5'd7,
        S_MEMWB    = 5'd8,
        S_MEMWRITE = 5'd9,
        S_BRANCH   = 5'd10,
        S_JAL      = 5'd11,
        S_JALR     = 5'd12,
        S_JLINK    = 5'd13,
        S_MULDIV   = 5'd14,
        S_MDWB     = 5'd15,
        S_TRAP     = 5'd16
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_md_cnt;
    logic [CNT_W-1:0] r_instret;
    logic             r_illegal;

    // funct7[5] only matters for funct3 000 (R-type SUB) and 101 (SRA)
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       alt,
                                              input logic       is_r);
        logic [3:0] op;
        op = c_alu_add;
        case (f3)
            3'b000:  op = (is_r && alt) ? c_alu_sub : c_alu_add;
            3'b001:  op = c_alu_sll;
            3'b010:  op = c_alu_slt;
            3'b011:  op = c_alu_sltu;
            3'b100:  op = c_alu_xor;
            3'b101:  op = alt ? c_alu_sra : c_alu_srl;
            3'b110:  op = c_alu_or;
            default: op = c_alu_and;
        endcase
        return op;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Mul/div countdown: loaded as the FSM enters MULDIV, stops at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt <= 8'd0;
        end else if (r_state == S_DECODE && w_next == S_MULDIV) begin
            r_md_cnt <= c_md_load;
        end else if (r_state == S_MULDIV && r_md_cnt != 8'd0) begin
            r_md_cnt <= r_md_cnt - 8'd1;
        end
    end

    // Retired count and sticky trap flag; IDLE->FETCH and FETCH wait cycles do not retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_next == S_FETCH && r_state != S_IDLE && r_state != S_FETCH) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (w_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign instret = r_instret;
    assign illegal = r_illegal;

    // Next-state and control outputs; PCWrite/IRWrite are the only Mealy terms
    always_comb begin
        w_next      = r_state;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        AdrSrc      = 1'b0;
        MemReq      = 1'b0;
        MemRW       = 1'b0;
        RegWEn      = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        Branch      = 1'b0;
        BrUn        = 1'b0;
        alu_control = c_alu_add;
        md_start    = 1'b0;
        md_busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    c_op_r: begin
                        if (funct7 == c_f7_muldiv) begin
                            w_next = c_md_en ? S_MULDIV : S_TRAP;
                        end else begin
                            w_next = S_EXECR;
                        end
                    end
                    c_op_i, c_op_lui, c_op_auipc: w_next = S_EXECI;
                    c_op_load, c_op_store:        w_next = S_MEMADR;
                    c_op_branch:                  w_next = S_BRANCH;
                    c_op_jal:                     w_next = S_JAL;
                    c_op_jalr:                    w_next = S_JALR;
                    default:                      w_next = S_TRAP;
                endcase
            end
            S_EXECR: begin
                ALUSrcA     = 2'b10;
                alu_control = alu_decode(funct3, funct7[5], 1'b1);
                w_next      = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB = 2'b01;
                if (opcode == c_op_lui) begin
                    ALUSrcA = 2'b11;
                end else if (opcode == c_op_auipc) begin
                    ALUSrcA = 2'b01;
                end else begin
                    ALUSrcA     = 2'b10;
                    alu_control = alu_decode(funct3, funct7[5], 1'b0);
                end
                w_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWEn = 1'b1;
                w_next = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (opcode == c_op_load) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                RegWEn    = 1'b1;
                ResultSrc = 2'b01;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                MemRW  = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                ALUSrcA     = 2'b10;
                alu_control = c_alu_sub;
                Branch      = 1'b1;
                BrUn        = funct3[1];
                PCWrite     = br_taken;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                w_next  = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                w_next    = S_JLINK;
            end
            S_JLINK: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                w_next  = S_ALUWB;
            end
            S_MULDIV: begin
                md_busy  = 1'b1;
                // The counter still holds its load value only in the first cycle
                md_start = (r_md_cnt == c_md_load);
                if (r_md_cnt == 8'd0) begin
                    w_next = S_MDWB;
                end
            end
            S_MDWB: begin
                RegWEn    = 1'b1;
                ResultSrc = 2'b11;
                w_next    = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
